// File: rtl/asyn_fifo_pkg.sv
// Shared helpers for the async FIFO write- and read-side controllers.
// Gray/binary converters take a zero-extended vector of up to 32 bits.
// Leading zeros do not change either conversion, so callers cast the
// argument up and the result back down to their own width.
package asyn_fifo_pkg;

  // A pointer carries one lap bit above the RAM address.
  localparam int PTR_EXTRA_BITS = 1;
  localparam int CONV_WIDTH = 32;

  function automatic int ptr_width(input int addr_width);
    return addr_width + PTR_EXTRA_BITS;
  endfunction

  function automatic logic [CONV_WIDTH-1:0] bin2gray(input logic [CONV_WIDTH-1:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [CONV_WIDTH-1:0] gray2bin(input logic [CONV_WIDTH-1:0] g);
    logic [CONV_WIDTH-1:0] b;
    b = g;
    for (int i = 1; i < CONV_WIDTH; i++) begin
      b = b ^ (g >> i);
    end
    return b;
  endfunction

endpackage

// File: rtl/asyn_fifo_gray2bin.sv
// Combinational Gray-to-binary converter.
// Each binary bit is the XOR of all Gray bits at or above it. Every bit is a
// direct reduction, so there is no ripple chain through the output vector.
module asyn_fifo_gray2bin #(
  parameter int W = 7
) (
  input  logic [W-1:0] g,
  output logic [W-1:0] b
);

  genvar gi;
  generate
    for (gi = 0; gi < W; gi++) begin : g_bit
      assign b[gi] = ^g[W-1:gi];
    end
  endgenerate

endmodule

// File: rtl/asyn_fifo_write_ctrl.sv
// Write-domain controller of the async FIFO.
// Holds the binary and Gray write pointers and drives the RAM write port.
// Produces a registered, pessimistic full flag from the synced Gray read
// pointer, and a sticky overflow flag.
// Optional macro WRITE_LEVEL_EN adds the write_level and almost_full outputs.
module asyn_fifo_write_ctrl
  import asyn_fifo_pkg::*;
#(
  parameter int ADDR_WIDTH         = 6,
  parameter int ALMOST_FULL_THRESH = 48
) (
  input  logic                  write_clk,
  input  logic                  write_rst_n,
  input  logic                  write_en,
  input  logic [ADDR_WIDTH:0]   sync_read_to_write,
  input  logic                  clear_overflow,
  output logic [ADDR_WIDTH-1:0] write_addr,
  output logic                  write_mem_en,
  output logic [ADDR_WIDTH:0]   write_ptr,
  output logic                  full,
  output logic                  overflow
`ifdef WRITE_LEVEL_EN
  ,
  output logic [ADDR_WIDTH:0]   write_level,
  output logic                  almost_full
`endif
);

  localparam int PW = ptr_width(ADDR_WIDTH);
  localparam int AW = ADDR_WIDTH;

  logic [PW-1:0] wbin;
  logic [PW-1:0] wbin_next;
  logic [PW-1:0] wgray_next;
  logic [PW-1:0] read_gray_full;
  logic          push;
  logic          full_next;
  logic          overflow_next;

  // A push is only accepted while not full. The reset gate keeps the RAM
  // strobe quiet while the controller is held in reset.
  assign push         = write_en & ~full;
  assign write_mem_en = push & write_rst_n;
  assign write_addr   = wbin[AW-1:0];

  assign wbin_next  = wbin + PW'(push);
  assign wgray_next = PW'(bin2gray(32'(wbin_next)));

  // A full FIFO's Gray write pointer equals the read pointer with its top two
  // bits inverted, which is one lap ahead at the same address.
  assign read_gray_full = {~sync_read_to_write[AW:AW-1], sync_read_to_write[AW-2:0]};
  assign full_next      = (wgray_next == read_gray_full);

  // A set has priority over a clear in the same cycle, so no overflow event is lost.
  assign overflow_next = (write_en & full) | (overflow & ~clear_overflow);

  // Pointer, full and overflow registers.
  always_ff @(posedge write_clk or negedge write_rst_n) begin
    if (!write_rst_n) begin
      wbin      <= '0;
      write_ptr <= '0;
      full      <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      wbin      <= wbin_next;
      write_ptr <= wgray_next;
      full      <= full_next;
      overflow  <= overflow_next;
    end
  end

`ifdef WRITE_LEVEL_EN
  logic [PW-1:0] read_bin;
  logic [PW-1:0] level_next;

  asyn_fifo_gray2bin #(
    .W (PW)
  ) u_read_gray2bin (
    .g (sync_read_to_write),
    .b (read_bin)
  );

  // Modular difference. The lap bit makes a full FIFO read 2**AW instead of 0.
  assign level_next = wbin_next - read_bin;

  // Registered occupancy and almost-full, both seen through the synced read pointer.
  always_ff @(posedge write_clk or negedge write_rst_n) begin
    if (!write_rst_n) begin
      write_level <= '0;
      almost_full <= 1'b0;
    end else begin
      write_level <= level_next;
      almost_full <= (level_next >= PW'(ALMOST_FULL_THRESH));
    end
  end
`endif

endmodule

// File: tb/tb_asyn_fifo_write_ctrl.sv
// Self-checking bench for asyn_fifo_write_ctrl (ADDR_WIDTH=6).
// The reference model tracks the total number of accepted writes and the total
// number of reads, both as plain integers. Occupancy is their difference. Full
// means that difference is 64. Expected pointers are derived from the write total.
// The level and almost_full checks are compiled in when WRITE_LEVEL_EN is defined.
module tb_asyn_fifo_write_ctrl;

  localparam int AW     = 6;
  localparam int PW     = 7;
  localparam int DEPTH  = 64;
  localparam int THRESH = 48;

  logic          write_clk = 1'b0;
  logic          write_rst_n = 1'b0;
  logic          write_en = 1'b0;
  logic          clear_overflow = 1'b0;
  logic [PW-1:0] sync_read_to_write = '0;
  logic [AW-1:0] write_addr;
  logic          write_mem_en;
  logic [PW-1:0] write_ptr;
  logic          full;
  logic          overflow;
`ifdef WRITE_LEVEL_EN
  logic [PW-1:0] write_level;
  logic          almost_full;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  int wtotal   = 0;
  int rtotal   = 0;
  bit exp_full = 1'b0;
  bit exp_ovf  = 1'b0;
  bit saw_full = 1'b0;

  asyn_fifo_write_ctrl #(
    .ADDR_WIDTH         (AW),
    .ALMOST_FULL_THRESH (THRESH)
  ) dut (
    .write_clk          (write_clk),
    .write_rst_n        (write_rst_n),
    .write_en           (write_en),
    .sync_read_to_write (sync_read_to_write),
    .clear_overflow     (clear_overflow),
    .write_addr         (write_addr),
    .write_mem_en       (write_mem_en),
    .write_ptr          (write_ptr),
    .full               (full),
    .overflow           (overflow)
`ifdef WRITE_LEVEL_EN
    ,
    .write_level        (write_level),
    .almost_full        (almost_full)
`endif
  );

  always #5 write_clk = ~write_clk;

  function automatic logic [PW-1:0] gray_of(input int n);
    logic [PW-1:0] b;
    b = PW'(n % 128);
    return b ^ (b >> 1);
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  // One write-clock cycle. Call it 1 time unit after a rising edge. It drives
  // the inputs, checks the combinational outputs, advances the model, then
  // checks the registered outputs after the next rising edge.
  task automatic cycle(input bit we, input bit clr, input int rd);
    bit push;
    int lvl;
    write_en           = we;
    clear_overflow     = clr;
    rtotal             = rd;
    sync_read_to_write = gray_of(rd);
    #1;
    push = we && !exp_full;
    check("write_mem_en", write_mem_en, push);
    check("write_addr", write_addr, wtotal % DEPTH);
    if (push) wtotal++;
    if (we && exp_full) exp_ovf = 1'b1;
    else if (clr) exp_ovf = 1'b0;
    lvl      = wtotal - rtotal;
    exp_full = (lvl == DEPTH);
    @(posedge write_clk);
    #1;
    check("write_ptr", write_ptr, gray_of(wtotal));
    check("full", full, exp_full);
    check("overflow", overflow, exp_ovf);
    if (full) saw_full = 1'b1;
`ifdef WRITE_LEVEL_EN
    check("write_level", write_level, lvl);
    check("almost_full", almost_full, lvl >= THRESH);
`endif
    $display("cyc we=%0b push=%0b clr=%0b rd=%0d wr=%0d ptr=%b full=%0b ovf=%0b",
             we, push, clr, rd, wtotal, write_ptr, full, overflow);
  endtask

  // Asynchronous reset asserted mid-cycle with write_en high. All outputs must
  // clear at once and stay clear across a clock edge while reset is held.
  task automatic do_reset();
    write_en       = 1'b1;
    clear_overflow = 1'b0;
    @(negedge write_clk);
    #2;
    write_rst_n = 1'b0;
    #1;
    check("rst_ptr_async", write_ptr, 0);
    check("rst_full_async", full, 0);
    check("rst_ovf_async", overflow, 0);
    check("rst_addr_async", write_addr, 0);
    check("rst_mem_en_async", write_mem_en, 0);
`ifdef WRITE_LEVEL_EN
    check("rst_level_async", write_level, 0);
    check("rst_af_async", almost_full, 0);
`endif
    @(posedge write_clk);
    #1;
    check("rst_ptr_held", write_ptr, 0);
    check("rst_mem_en_held", write_mem_en, 0);
    @(negedge write_clk);
    write_rst_n        = 1'b1;
    write_en           = 1'b0;
    sync_read_to_write = '0;
    wtotal   = 0;
    rtotal   = 0;
    exp_full = 1'b0;
    exp_ovf  = 1'b0;
    saw_full = 1'b0;
    @(posedge write_clk);
    #1;
    $display("reset released");
  endtask

  initial begin
    // Reset, then fill: the first push writes address 0; 64 pushes reach full.
    do_reset();
    for (int i = 0; i < DEPTH; i++) cycle(1'b1, 1'b0, 0);
    check("fill_full", full, 1);
    check("fill_ptr", write_ptr, 7'b1100000);
    check("fill_addr", write_addr, 0);

    // Overflow: the push is dropped, overflow sets; clear; set wins over clear.
    cycle(1'b1, 1'b0, 0);
    check("ovf_set", overflow, 1);
    check("ovf_ptr_hold", write_ptr, 7'b1100000);
    cycle(1'b0, 1'b1, 0);
    check("ovf_clear", overflow, 0);
    cycle(1'b1, 1'b1, 0);
    check("ovf_set_wins", overflow, 1);
    cycle(1'b0, 1'b1, 0);

    // Drain one entry: full drops, then one push refills address 0.
    cycle(1'b0, 1'b0, 1);
    check("drain_full", full, 0);
    cycle(1'b1, 1'b0, 1);
    check("refill_full", full, 1);

    // Wrap: the read pointer trails by 3, so full must never assert.
    do_reset();
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 0);
    for (int i = 0; i < 200; i++) begin
      cycle(1'b1, 1'b0, wtotal - 3);
      if (wtotal == 127) check("wrap_ptr_127", write_ptr, 7'b1000000);
      if (wtotal == 128) check("wrap_ptr_0", write_ptr, 7'b0000000);
    end
    check("wrap_no_full", saw_full, 0);

`ifdef WRITE_LEVEL_EN
    // Level: 50 pushes, then the read pointer at 3 gives 47, and one more push gives 48.
    do_reset();
    for (int i = 0; i < 50; i++) cycle(1'b1, 1'b0, 0);
    cycle(1'b0, 1'b0, 3);
    check("lvl_47", write_level, 47);
    check("af_below", almost_full, 0);
    cycle(1'b1, 1'b0, 3);
    check("lvl_48", write_level, 48);
    check("af_at", almost_full, 1);
`endif

    // Random traffic: reads are slower than writes, so full and overflow recur.
    do_reset();
    for (int i = 0; i < 600; i++) begin
      bit we;
      bit clr;
      int rd;
      we  = ($urandom_range(0, 3) != 0);
      clr = ($urandom_range(0, 7) == 0);
      rd  = rtotal;
      if ($urandom_range(0, 2) == 0 && rtotal < wtotal) rd = rtotal + 1;
      cycle(we, clr, rd);
    end
    check("rand_saw_full", saw_full, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
